// File: rtl/coeff_load_sequencer.sv
// coeff_load_sequencer: loads a coefficient set into the FIR datapath over the modwait handshake, with abort and watchdog
module coeff_load_sequencer #(
  parameter int NUM_COEFFS     = 4,
  parameter int IDX_W          = $clog2(NUM_COEFFS),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             new_coefficient_set,
  input  logic             modwait,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             clear_new_coeff,
  output logic             busy,
  output logic             err_timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_IDLE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [2:0] ERROR     = 3'd5;

  logic [2:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err, err_n;

  // next-state logic; a withdrawn request beats any advance or timeout
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      IDLE: if (new_coefficient_set && !modwait) begin
        state_n = LOAD;
        idx_n   = '0;
        err_n   = 1'b0;
      end
      LOAD: begin
        cnt_n   = '0;
        state_n = new_coefficient_set ? WAIT_BUSY : IDLE;
        idx_n   = new_coefficient_set ? idx : '0;
      end
      WAIT_BUSY: if (!new_coefficient_set) begin
        state_n = IDLE;
        idx_n   = '0;
      end else if (modwait) begin
        state_n = WAIT_IDLE;
      end else if (cnt == CNT_LAST) begin
        state_n = ERROR;
        err_n   = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      WAIT_IDLE: if (!new_coefficient_set) begin
        state_n = IDLE;
        idx_n   = '0;
      end else if (!modwait) begin
        state_n = (idx == LAST_IDX) ? DONE : LOAD;
        idx_n   = (idx == LAST_IDX) ? idx : idx + 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      ERROR: if (!new_coefficient_set) begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // state, index, watchdog counter and sticky error registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  assign load_coeff      = state == LOAD;
  assign clear_new_coeff = state == DONE;
  assign busy            = state != IDLE;
  assign coefficient_num = idx;
  assign err_timeout     = err;
endmodule

// File: tb/tb_coeff_load_sequencer.sv
// tb_coeff_load_sequencer: directed checks of the coefficient load sequencer for 4- and 8-coefficient sets
module tb_coeff_load_sequencer;
  localparam int DP_LEN = 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic set4 = 1'b0, fmw4 = 1'b0, dp_mw4 = 1'b0, dp_en4 = 1'b0, mw4;
  logic set8 = 1'b0, dp_mw8 = 1'b0, dp_en8 = 1'b0, mw8;
  logic ld4, clr4, busy4, err4;
  logic ld8, clr8, busy8, err8;
  logic [1:0] num4;
  logic [2:0] num8;
  logic [2:0] log4 [64];
  logic [2:0] log8 [64];
  int checks = 0, errors = 0;
  int n4 = 0, n8 = 0, c4 = 0, c8 = 0, rem4 = 0, rem8 = 0;
  int s0, c0, k;

  coeff_load_sequencer #(.NUM_COEFFS(4), .IDX_W(2), .TIMEOUT_CYCLES(16)) d4 (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(set4), .modwait(mw4),
    .load_coeff(ld4), .coefficient_num(num4), .clear_new_coeff(clr4),
    .busy(busy4), .err_timeout(err4)
  );

  coeff_load_sequencer #(.NUM_COEFFS(8), .IDX_W(3), .TIMEOUT_CYCLES(16)) d8 (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(set8), .modwait(mw8),
    .load_coeff(ld8), .coefficient_num(num8), .clear_new_coeff(clr8),
    .busy(busy8), .err_timeout(err8)
  );

  always #5 clk = ~clk;

  assign mw4 = dp_mw4 | fmw4;
  assign mw8 = dp_mw8;

  // datapath model: modwait high for DP_LEN cycles starting the cycle after a strobe; also logs strobes and clears
  always @(negedge clk) begin
    dp_mw4 = rem4 > 0;
    if (rem4 > 0) rem4--;
    if (dp_en4 && ld4) rem4 = DP_LEN;
    if (ld4) begin log4[n4[5:0]] = {1'b0, num4}; n4++; end
    if (clr4) c4++;
    dp_mw8 = rem8 > 0;
    if (rem8 > 0) rem8--;
    if (dp_en8 && ld8) rem8 = DP_LEN;
    if (ld8) begin log8[n8[5:0]] = num8; n8++; end
    if (clr8) c8++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit big, input string tag);
    int t = 0;
    while (!(big ? clr8 : clr4) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(big ? clr8 : clr4), 1);
    if (big) set8 = 1'b0; else set4 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_load", 32'(ld4), 0);
    chk("rst_num", 32'(num4), 0);
    chk("rst_clear", 32'(clr4), 0);
    chk("rst_err", 32'(err4), 0);
    chk("rst_busy8", 32'(busy8), 0);
    n_rst = 1'b1;
    @(negedge clk);

    dp_en4 = 1'b1; set4 = 1'b1; s0 = n4; c0 = c4;
    @(negedge clk);
    chk("t1_first_strobe", 32'(ld4), 1);
    chk("t1_first_idx", 32'(num4), 0);
    wait_done(1'b0, "t1_done");
    @(negedge clk);
    chk("t1_idle", 32'(busy4), 0);
    chk("t1_strobes", n4 - s0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_idx%0d", i), 32'(log4[6'(s0 + i)]), i);
    chk("t1_clears", c4 - c0, 1);

    fmw4 = 1'b1; set4 = 1'b1; s0 = n4;
    repeat (5) @(negedge clk);
    chk("t2_held_strobes", n4 - s0, 0);
    chk("t2_held_busy", 32'(busy4), 0);
    fmw4 = 1'b0;
    @(negedge clk);
    chk("t2_strobe", 32'(ld4), 1);
    chk("t2_idx", 32'(num4), 0);
    wait_done(1'b0, "t2_done");
    @(negedge clk);

    set4 = 1'b1; c0 = c4; k = 0;
    while (!(ld4 && num4 == 2'd2) && k < 100) begin @(negedge clk); k++; end
    chk("t3_reach_idx2", 32'(ld4 && num4 == 2'd2), 1);
    repeat (2) @(negedge clk);
    chk("t3_wait_idle_busy", 32'(busy4), 1);
    chk("t3_wait_idle_idx", 32'(num4), 2);
    set4 = 1'b0;
    @(negedge clk);
    chk("t3_abort_busy", 32'(busy4), 0);
    chk("t3_abort_idx", 32'(num4), 0);
    repeat (3) @(negedge clk);
    chk("t3_no_clear", c4 - c0, 0);
    set4 = 1'b1;
    @(negedge clk);
    chk("t3_restart_strobe", 32'(ld4), 1);
    chk("t3_restart_idx", 32'(num4), 0);
    wait_done(1'b0, "t3_done");
    @(negedge clk);

    dp_en4 = 1'b0; set4 = 1'b1;
    @(negedge clk);
    chk("t4_strobe", 32'(ld4), 1);
    repeat (16) @(negedge clk);
    chk("t4_pre_expiry_err", 32'(err4), 0);
    chk("t4_pre_expiry_busy", 32'(busy4), 1);
    @(negedge clk);
    chk("t4_err", 32'(err4), 1);
    chk("t4_err_no_load", 32'(ld4), 0);
    set4 = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(busy4), 0);
    chk("t4_err_sticky", 32'(err4), 1);
    dp_en4 = 1'b1; set4 = 1'b1;
    @(negedge clk);
    chk("t4_reload", 32'(ld4), 1);
    chk("t4_err_cleared", 32'(err4), 0);
    wait_done(1'b0, "t4_done");
    @(negedge clk);

    dp_en4 = 1'b0; set4 = 1'b1;
    @(negedge clk);
    repeat (16) @(negedge clk);
    fmw4 = 1'b1;
    @(negedge clk);
    chk("t5_no_err", 32'(err4), 0);
    chk("t5_busy", 32'(busy4), 1);
    fmw4 = 1'b0;
    @(negedge clk);
    chk("t5_next_strobe", 32'(ld4), 1);
    chk("t5_next_idx", 32'(num4), 1);
    set4 = 1'b0;
    @(negedge clk);
    chk("t5_abort_in_load", 32'(busy4), 0);

    set4 = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_in_wait_busy", 32'(busy4), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy4), 0);
    chk("t6_rst_load", 32'(ld4), 0);
    chk("t6_rst_num", 32'(num4), 0);
    chk("t6_rst_err", 32'(err4), 0);
    set4 = 1'b0;
    @(negedge clk);
    n_rst = 1'b1; s0 = n4;
    repeat (2) @(negedge clk);
    chk("t6_no_partial", n4 - s0, 0);
    chk("t6_idle", 32'(busy4), 0);

    dp_en8 = 1'b1; set8 = 1'b1; s0 = n8; c0 = c8;
    wait_done(1'b1, "t6_done8");
    @(negedge clk);
    chk("t6_idle8", 32'(busy8), 0);
    chk("t6_strobes8", n8 - s0, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_idx8_%0d", i), 32'(log8[6'(s0 + i)]), i);
    chk("t6_clears8", c8 - c0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
